// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: takes one 10-bit command per handshake and frames it on SS_n/MOSI,
// one bit per clk, capturing an 8-bit MISO reply for read-data commands.
module spi_master_ctrl #(
  parameter int TAIL_CYC  = 2,
  parameter int RD_WAIT   = 2,
  parameter int DESEL_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT,
    TAIL,
    RD_WAIT_ST,
    CAPTURE,
    DESELECT
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] CAP_LAST   = 4'd7;
  localparam logic [3:0] TAIL_LAST  = 4'(TAIL_CYC - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] DESEL_LAST = 4'(DESEL_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  word_q, word_d;
  logic        rd_q, rd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  // Handshake: a command transfers on a rising edge where req_valid and req_ready are both 1;
  // req_ready is high only in IDLE, so req_valid while busy is simply not observed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 4'd1;
    word_d      = word_q;
    rd_d        = rd_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ss_n_d      = 1'b0;
    mosi_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = 4'd0;
        ss_n_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = SELECT;
          rd_d    = (req_op == 2'b11);
          word_d  = (req_op == 2'b11) ? {2'b11, 8'h00} : {req_op, req_data};
          ss_n_d  = 1'b0;
          mosi_d  = req_op[1];
        end
      end
      SELECT: begin
        state_d = SHIFT;
        cnt_d   = 4'd0;
        mosi_d  = word_q[9];
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = rd_q ? RD_WAIT_ST : TAIL;
          cnt_d   = 4'd0;
        end else begin
          // Bit 9 is already on the wire; expose the next bit and shift it into place.
          mosi_d = word_q[8];
          word_d = {word_q[8:0], 1'b0};
        end
      end
      TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          state_d = DESELECT;
          cnt_d   = 4'd0;
          ss_n_d  = 1'b1;
        end
      end
      RD_WAIT_ST: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = CAPTURE;
          cnt_d   = 4'd0;
        end
      end
      CAPTURE: begin
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == CAP_LAST) begin
          state_d     = DESELECT;
          cnt_d       = 4'd0;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[6:0], MISO};
        end
      end
      DESELECT: begin
        ss_n_d = 1'b1;
        if (cnt_q == DESEL_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        ss_n_d  = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      word_q      <= 10'd0;
      rd_q        <= 1'b0;
      rx_q        <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule
